// File: rtl/if_stage.sv
// if_stage: instruction fetch with variable-latency I-cache, redirect drain and one-entry skid buffer
module if_stage #(
  parameter int PC_W = 16,
  parameter int INSTR_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               icache_req,
  output logic [PC_W-1:0]    icache_addr,
  input  logic               icache_ready,
  input  logic [INSTR_W-1:0] icache_data,
  input  logic               pc_source,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    target_pc,
  input  logic               id_stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [6:0]         opcode
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;
  state_t state;
  logic [PC_W-1:0] pc, pend, skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic redir, accept;
  assign redir = redirect_valid && !pc_source && !id_stall;
  assign accept = icache_req && icache_ready;
  assign icache_req = state == FETCH || state == DRAIN;
  assign icache_addr = pc;
  assign opcode = if_instr[INSTR_W-1 -: 7];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      pend <= '0;
      skid_pc <= '0;
      skid_instr <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc <= '0;
    end else begin
      // default bubble whenever ID advances; overridden below on delivery
      if (!id_stall) if_valid <= 1'b0;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (accept && redir) pc <= target_pc;
          else if (accept) begin
            pc <= pc + PC_W'(1);
            if (!id_stall || !if_valid) begin
              if_valid <= 1'b1;
              if_instr <= icache_data;
              if_pc <= pc;
            end else begin
              skid_instr <= icache_data;
              skid_pc <= pc;
              state <= HOLD;
            end
          end else if (redir) begin
            pend <= target_pc;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (redir) pend <= target_pc;
          if (accept) begin
            pc <= redir ? target_pc : pend;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (redir) begin
            pc <= target_pc;
            state <= FETCH;
          end else if (!id_stall) begin
            if_valid <= 1'b1;
            if_instr <= skid_instr;
            if_pc <= skid_pc;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
